// File: rtl/frame_buffer_single_port.sv
// frame_buffer_single_port: single-port 16-bit framebuffer arbitrating fragment
// read/write, a clear sweep and an AXI-Stream read-out sweep.
module frame_buffer_single_port #(
  parameter int FRAMEBUFFER_INDEX_WIDTH = 14
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] fragIndexRead,
  input  logic                               fragReadEnable,
  output logic [15:0]                        fragDataOut,
  input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] fragIndexWrite,
  input  logic                               fragWriteEnable,
  input  logic [15:0]                        fragDataIn,
  input  logic [15:0]                        confClearColor,
  input  logic                               clearStart,
  input  logic                               streamStart,
  output logic                               busy,
  output logic                               collision,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic [15:0]                        m_axis_tdata
);
  localparam int W = FRAMEBUFFER_INDEX_WIDTH;
  localparam int SIZE = 2 ** W;
  typedef enum logic [1:0] {IDLE, CLEAR, STREAM} state_t;
  state_t      r_state;
  logic [15:0] r_mem [SIZE];
  logic [W:0]  r_ptr;
  logic [15:0] r_sdata;
  logic        r_slast;
  logic        r_inflight;
  logic [15:0] r_fd [2];
  logic [1:0]  r_fl;
  logic        r_wp;
  logic        r_rp;
  logic [1:0]  r_cnt;
  logic        r_collision;
  logic [15:0] r_frag_out;
  logic          w_idle;
  logic [W-1:0]  w_addr;
  logic          w_we;
  logic [15:0]   w_wdata;
  logic          w_frag_rd;
  logic          w_pop;
  logic [2:0]    w_occ;
  logic          w_issue;
  logic [W:0]    w_ptr_nx;
  assign w_idle    = r_state == IDLE;
  assign w_addr    = !w_idle ? r_ptr[W-1:0] : fragWriteEnable ? fragIndexWrite : fragIndexRead;
  assign w_we      = !reset && (r_state == CLEAR || (w_idle && fragWriteEnable));
  assign w_wdata   = w_idle ? fragDataIn : confClearColor;
  assign w_frag_rd = w_idle && fragReadEnable && !fragWriteEnable;
  assign w_pop     = m_axis_tvalid && m_axis_tready;
  // occupancy after this cycle's pop, counting the read already in flight
  assign w_occ     = {1'b0, r_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue   = r_state == STREAM && !r_ptr[W] && w_occ < 3'd2;
  assign w_ptr_nx  = r_ptr + (W+1)'(1);
  assign busy          = !w_idle;
  assign collision     = r_collision;
  assign fragDataOut   = r_frag_out;
  assign m_axis_tvalid = r_cnt != 2'd0;
  assign m_axis_tdata  = r_fd[r_rp];
  assign m_axis_tlast  = r_fl[r_rp];
  always_ff @(posedge clk)
    if (w_we) r_mem[w_addr] <= w_wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_sdata     <= '0;
      r_slast     <= 1'b0;
      r_inflight  <= 1'b0;
      r_fd[0]     <= '0;
      r_fd[1]     <= '0;
      r_fl        <= '0;
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_cnt       <= '0;
      r_collision <= 1'b0;
      r_frag_out  <= '0;
    end else begin
      if ((fragWriteEnable && fragReadEnable) || (!w_idle && (fragWriteEnable || fragReadEnable)))
        r_collision <= 1'b1;
      if (w_frag_rd) r_frag_out <= r_mem[w_addr];
      r_inflight <= w_issue;
      if (w_issue) begin
        r_sdata <= r_mem[w_addr];
        r_slast <= &r_ptr[W-1:0];
      end
      if (r_inflight) begin
        r_fd[r_wp] <= r_sdata;
        r_fl[r_wp] <= r_slast;
        r_wp       <= !r_wp;
      end
      if (w_pop) r_rp <= !r_rp;
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
      case (r_state)
        IDLE: begin
          r_ptr   <= '0;
          r_state <= clearStart ? CLEAR : streamStart ? STREAM : IDLE;
        end
        CLEAR: begin
          r_ptr   <= w_ptr_nx[W] ? '0 : w_ptr_nx;
          r_state <= w_ptr_nx[W] ? IDLE : CLEAR;
        end
        STREAM: begin
          if (w_issue) r_ptr <= w_ptr_nx;
          if (w_pop && m_axis_tlast) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_buffer_single_port.sv
// tb_frame_buffer_single_port: scoreboard bench for the framebuffer (SIZE=16).
module tb_frame_buffer_single_port;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  fragIndexRead = '0;
  logic        fragReadEnable = 1'b0;
  logic [15:0] fragDataOut;
  logic [3:0]  fragIndexWrite = '0;
  logic        fragWriteEnable = 1'b0;
  logic [15:0] fragDataIn = '0;
  logic [15:0] confClearColor = '0;
  logic        clearStart = 1'b0;
  logic        streamStart = 1'b0;
  logic        busy;
  logic        collision;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [15:0] m_axis_tdata;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_mem [16];
  logic [16:0] exp_q [$];
  frame_buffer_single_port #(.FRAMEBUFFER_INDEX_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .fragIndexRead(fragIndexRead), .fragReadEnable(fragReadEnable), .fragDataOut(fragDataOut),
    .fragIndexWrite(fragIndexWrite), .fragWriteEnable(fragWriteEnable), .fragDataIn(fragDataIn),
    .confClearColor(confClearColor), .clearStart(clearStart), .streamStart(streamStart),
    .busy(busy), .collision(collision),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fwrite(input logic [3:0] a, input logic [15:0] d);
    fragWriteEnable = 1'b1;
    fragIndexWrite  = a;
    fragDataIn      = d;
    step();
    fragWriteEnable = 1'b0;
    exp_mem[a]      = d;
  endtask
  task automatic fread(input string tag, input logic [3:0] a);
    fragReadEnable = 1'b1;
    fragIndexRead  = a;
    step();
    fragReadEnable = 1'b0;
    chk(tag, fragDataOut, exp_mem[a]);
  endtask
  task automatic do_clear(input logic [15:0] color, input int inj);
    int n;
    confClearColor = color;
    clearStart = 1'b1;
    step();
    clearStart = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      fragWriteEnable = (n == inj);
      fragIndexWrite  = 4'd2;
      fragDataIn      = 16'hDEAD;
      step();
    end
    fragWriteEnable = 1'b0;
    chk("clear_busy_cycles", n, 16);
    for (int i = 0; i < 16; i++) exp_mem[i] = color;
  endtask
  task automatic preload();
    for (int i = 0; i < 16; i++) fwrite(4'(i), 16'(i));
  endtask
  task automatic run_stream(input int pct_low, input int abort_beat);
    int          cyc, beats, first;
    logic        stall;
    logic [16:0] held, w;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back({i == 15, exp_mem[i]});
    streamStart = 1'b1;
    step();
    streamStart = 1'b0;
    cyc = 1; beats = 0; first = -1; stall = 1'b0; held = '0;
    while (cyc < 400) begin
      m_axis_tready = ($urandom_range(99) >= pct_low);
      if (stall) begin
        chk("stall_tvalid", m_axis_tvalid, 1);
        chk("stall_hold", {m_axis_tlast, m_axis_tdata}, held);
      end
      if (m_axis_tvalid && first < 0) first = cyc;
      if (abort_beat >= 0 && beats == abort_beat && m_axis_tvalid) begin
        reset = 1'b1;
        break;
      end
      if (!busy) break;
      if (m_axis_tvalid && m_axis_tready) begin
        w = exp_q.size() ? exp_q.pop_front() : 17'h1FFFF;
        chk("beat", {m_axis_tlast, m_axis_tdata}, w);
        beats++;
      end
      stall = m_axis_tvalid && !m_axis_tready;
      held  = {m_axis_tlast, m_axis_tdata};
      step();
      cyc++;
    end
    m_axis_tready = 1'b1;
    if (abort_beat < 0) begin
      chk("first_tvalid_cycle", first, 3);
      chk("beat_count", beats, 16);
      chk("queue_empty", exp_q.size(), 0);
      if (pct_low == 0) chk("busy_low_cycle", cyc, 19);
    end
  endtask
  initial begin
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_collision", collision, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_fragout", fragDataOut, 0);
    reset = 1'b0;
    step();
    fwrite(4'd5, 16'hABCD);
    fread("wr_rd_5", 4'd5);
    chk("no_collision", collision, 0);
    do_clear(16'h1234, -1);
    fread("clr_0", 4'd0);
    fread("clr_7", 4'd7);
    fread("clr_15", 4'd15);
    chk("clr_collision", collision, 0);
    fragWriteEnable = 1'b1;
    fragReadEnable  = 1'b1;
    fragIndexWrite  = 4'd3;
    fragIndexRead   = 4'd3;
    fragDataIn      = 16'h5A5A;
    step();
    fragWriteEnable = 1'b0;
    fragReadEnable  = 1'b0;
    exp_mem[3] = 16'h5A5A;
    chk("both_collision", collision, 1);
    chk("both_stale_read", fragDataOut, 16'h1234);
    step();
    step();
    chk("collision_sticky", collision, 1);
    fread("both_write_done", 4'd3);
    preload();
    run_stream(0, -1);
    run_stream(30, -1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_clears_collision", collision, 0);
    do_clear(16'h0F0F, 3);
    chk("busy_write_collision", collision, 1);
    fread("busy_write_dropped", 4'd2);
    preload();
    run_stream(0, 6);
    step();
    chk("abort_tvalid", m_axis_tvalid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_collision", collision, 0);
    reset = 1'b0;
    run_stream(0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
